lut_reconfig_sequencer: RTL and testbench

// - Sequences the LUT-to-frame-address translator for queued LUT reconfiguration jobs.
// - Buffers requests (XYBel + 16-bit INIT half), runs the translator once per job, then hands
//   {frame address, word offset, half select, data} to the downstream frame read-modify-write engine.
// - Sits between the software/DMA request port and the ICAP frame datapath; sole owner of the translator.

---
 rtl/lut_reconfig_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_lut_reconfig_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_reconfig_sequencer.sv
//-----------------------------------------------------------------------------
// lut_reconfig_sequencer
//
// Purpose:
//   Queues LUT reconfiguration jobs (target XYBel plus one 16-bit INIT half)
//   and runs the LUT-to-frame-address translator once per job. Each result is
//   handed to the downstream frame read-modify-write engine as a single
//   {frame address, word offset, half select, data} command. This block is the
//   only owner of the translator. Only one job is in flight at a time, and jobs
//   leave in strict FIFO order.
//
// Parameters:
//   FIFO_DEPTH   request queue entries (power of two, >= 2)
//   TIMEOUT_CYC  RUN cycles allowed without tr_done before the job is aborted
//
// Ports:
//   Clk, Reset                  clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready = queue not full)
//   req_xybel, req_init         {X[31:17],Y[16:2],Bel[1:0]}, INIT half-word
//   tr_reset/tr_start/tr_xybel  translator control (start is a held level)
//   tr_done, tr_far,
//   tr_word_offset, tr_msb_lsb  translator results (done is sticky)
//   cmd_valid/cmd_ready         command handshake to the frame engine
//   cmd_far/cmd_word/
//   cmd_half/cmd_data           command payload, stable while cmd_valid
//   busy                        sequencer active or queue non-empty
//   err_timeout                 sticky abort flag, cleared only by Reset
//   stat_jobs, stat_timeouts    completed / aborted job counters
//
// Configuration:
//   LUT_RECONFIG_STATS_EN  when defined, the statistics counters are built.
//                          When not defined, stat_jobs and stat_timeouts are
//                          tied to zero.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module lut_reconfig_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_xybel,
    input  logic [15:0] req_init,
    output logic        tr_reset,
    output logic        tr_start,
    output logic [31:0] tr_xybel,
    input  logic        tr_done,
    input  logic [31:0] tr_far,
    input  logic [7:0]  tr_word_offset,
    input  logic        tr_msb_lsb,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_far,
    output logic [7:0]  cmd_word,
    output logic        cmd_half,
    output logic [15:0] cmd_data,
    output logic        busy,
    output logic        err_timeout,
    output logic [15:0] stat_jobs,
    output logic [7:0]  stat_timeouts
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        RUN   = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t state;

    // Request queue storage. The payload is not reset; only pointers and the
    // count are reset.
    logic [31:0]      q_xybel [FIFO_DEPTH];
    logic [15:0]      q_init  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             push;
    logic             pop;
    logic [15:0]      job_init;
    logic [TMR_W-1:0] timer;
    logic             job_done;
    logic             job_abort;

    // Ready comes only from the registered count. A pop in the same cycle
    // does not make room for a push.
    assign req_ready = (count != FULL_CNT);
    assign push      = req_valid & req_ready;
    assign pop       = (state == IDLE) && (count != '0);

    // Handshake complete in ISSUE. cmd_valid is always high in that state.
    assign job_done  = (state == ISSUE) && cmd_ready;
    // Last allowed RUN cycle has passed without a done.
    assign job_abort = (state == RUN) && !tr_done && (timer == TMR_LAST);

    // Clear the translator while Reset is high and for the one CLR cycle
    // before every job. It is never cleared during RUN.
    assign tr_reset  = Reset | (state == CLR);
    assign busy      = (state != IDLE) || (count != '0);

    always_ff @(posedge Clk) begin
        if (push) begin
            q_xybel[wr_ptr] <= req_xybel;
            q_init[wr_ptr]  <= req_init;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Job sequencer. tr_start and all cmd_* outputs are registered here.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            tr_start    <= 1'b0;
            tr_xybel    <= '0;
            cmd_valid   <= 1'b0;
            cmd_far     <= '0;
            cmd_word    <= '0;
            cmd_half    <= 1'b0;
            cmd_data    <= '0;
            err_timeout <= 1'b0;
            timer       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        // Load the XYBel now so it is already valid while
                        // the translator is being cleared.
                        tr_xybel <= q_xybel[rd_ptr];
                        job_init <= q_init[rd_ptr];
                        state    <= CLR;
                    end
                end
                CLR: begin
                    tr_start <= 1'b1;
                    timer    <= '0;
                    state    <= RUN;
                end
                RUN: begin
                    if (tr_done) begin
                        cmd_far   <= tr_far;
                        cmd_word  <= tr_word_offset;
                        cmd_half  <= tr_msb_lsb;
                        cmd_data  <= job_init;
                        cmd_valid <= 1'b1;
                        state     <= ISSUE;
                    end else if (job_abort) begin
                        err_timeout <= 1'b1;
                        tr_start    <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ISSUE: begin
                    // tr_start stays high so the translator outputs stay
                    // frozen until the engine takes the command.
                    if (job_done) begin
                        cmd_valid <= 1'b0;
                        tr_start  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LUT_RECONFIG_STATS_EN
    // Saturating increment for the abort counter, so repeated failures
    // never wrap back to a small value.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stat_jobs     <= '0;
            stat_timeouts <= '0;
        end else begin
            if (job_done) begin
                stat_jobs <= stat_jobs + 16'd1;
            end
            if (job_abort) begin
                stat_timeouts <= sat_inc8(stat_timeouts);
            end
        end
    end
`else
    assign stat_jobs     = '0;
    assign stat_timeouts = '0;
`endif

endmodule

// File: tb/tb_lut_reconfig_sequencer.sv
`timescale 1ns/1ps

module tb_lut_reconfig_sequencer;

`ifdef LUT_RECONFIG_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_xybel;
    logic [15:0] req_init;
    logic        tr_reset;
    logic        tr_start;
    logic [31:0] tr_xybel;
    logic        tr_done = 1'b0;
    logic [31:0] tr_far;
    logic [7:0]  tr_word_offset;
    logic        tr_msb_lsb;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_far;
    logic [7:0]  cmd_word;
    logic        cmd_half;
    logic [15:0] cmd_data;
    logic        busy;
    logic        err_timeout;
    logic [15:0] stat_jobs;
    logic [7:0]  stat_timeouts;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    lut_reconfig_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_xybel(req_xybel), .req_init(req_init),
        .tr_reset(tr_reset), .tr_start(tr_start), .tr_xybel(tr_xybel),
        .tr_done(tr_done), .tr_far(tr_far),
        .tr_word_offset(tr_word_offset), .tr_msb_lsb(tr_msb_lsb),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_far(cmd_far), .cmd_word(cmd_word), .cmd_half(cmd_half),
        .cmd_data(cmd_data), .busy(busy), .err_timeout(err_timeout),
        .stat_jobs(stat_jobs), .stat_timeouts(stat_timeouts)
    );

    // Translator model. Its results are a fixed function of XYBel. tr_done
    // rises after 6 cycles with tr_start high, stays high until tr_reset,
    // and never rises while m_never is set.
    logic [3:0] m_cnt = 4'd0;
    logic       m_never = 1'b0;

    function automatic logic [31:0] f_far(input logic [31:0] x);
        return x ^ 32'h5A5A_C3C3;
    endfunction
    function automatic logic [7:0] f_word(input logic [31:0] x);
        return x[9:2] + 8'd3;
    endfunction
    function automatic logic f_half(input logic [31:0] x);
        return x[1];
    endfunction

    assign tr_far         = f_far(tr_xybel);
    assign tr_word_offset = f_word(tr_xybel);
    assign tr_msb_lsb     = f_half(tr_xybel);

    always @(posedge Clk) begin
        if (tr_reset) begin
            m_cnt   <= 4'd0;
            tr_done <= 1'b0;
        end else if (tr_start && !tr_done && !m_never) begin
            m_cnt <= m_cnt + 4'd1;
            if (m_cnt == 4'd5) tr_done <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input string tag, input logic [31:0] x, input logic [15:0] i);
        req_valid = 1'b1;
        req_xybel = x;
        req_init  = i;
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_cmd(input string tag, output int cyc);
        cyc = 0;
        while (!cmd_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check({tag, "_cmd_valid_seen"}, 32'(cmd_valid), 32'd1);
    endtask

    // Requires cmd_valid high and cmd_ready high. Checks the payload, then
    // lets the handshake happen.
    task automatic take_cmd(input string tag, input logic [31:0] x, input logic [15:0] i);
        check({tag, "_far"},  cmd_far,          f_far(x));
        check({tag, "_word"}, 32'(cmd_word),    32'(f_word(x)));
        check({tag, "_half"}, 32'(cmd_half),    32'(f_half(x)));
        check({tag, "_data"}, 32'(cmd_data),    32'(i));
        tick();
        check({tag, "_cmd_valid_drop"}, 32'(cmd_valid), 32'd0);
    endtask

    logic [31:0] jx [5];
    logic [15:0] ji [5];

    initial begin
        int cyc;
        bit seen;
        jx[0] = 32'h0012_3458; ji[0] = 16'hA001;
        jx[1] = 32'h00AB_CDEE; ji[1] = 16'hB002;
        jx[2] = 32'h7FFF_0001; ji[2] = 16'hC003;
        jx[3] = 32'h8000_FFF6; ji[3] = 16'hD004;
        jx[4] = 32'h1357_9BDF; ji[4] = 16'hE005;

        // Reset state
        Reset = 1'b1; req_valid = 1'b0; req_xybel = '0; req_init = '0; cmd_ready = 1'b0;
        repeat (3) tick();
        check("rst_tr_reset",  32'(tr_reset),  32'd1);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_tr_start",  32'(tr_start),  32'd0);
        check("rst_tr_xybel",  tr_xybel,       32'd0);
        check("rst_cmd_far",   cmd_far,        32'd0);
        check("rst_err",       32'(err_timeout), 32'd0);
        check("rst_stat_jobs", 32'(stat_jobs), 32'd0);
        Reset = 1'b0;
        tick();
        check("idle_tr_reset", 32'(tr_reset), 32'd0);

        // Single job, latency and translator handshake
        cmd_ready = 1'b1;
        push_one("j1", 32'hCAFE_1236, 16'h5A5A);
        check("j1_busy", 32'(busy), 32'd1);
        tick();
        check("j1_clr_tr_reset", 32'(tr_reset), 32'd1);
        check("j1_clr_tr_start", 32'(tr_start), 32'd0);
        check("j1_clr_tr_xybel", tr_xybel, 32'hCAFE_1236);
        tick();
        check("j1_run_tr_reset", 32'(tr_reset), 32'd0);
        check("j1_run_tr_start", 32'(tr_start), 32'd1);
        wait_cmd("j1", cyc);
        check("j1_latency", 32'(cyc), 32'd7);
        check("j1_issue_tr_start", 32'(tr_start), 32'd1);
        take_cmd("j1", 32'hCAFE_1236, 16'h5A5A);
        check("j1_busy_end", 32'(busy), 32'd0);
        check("j1_stat_jobs", 32'(stat_jobs), STATS ? 32'd1 : 32'd0);

        // Five back-to-back jobs with the engine stalled
        cmd_ready = 1'b0;
        for (int k = 0; k < 5; k++) push_one($sformatf("q%0d", k), jx[k], ji[k]);
        check("q_full_ready", 32'(req_ready), 32'd0);
        wait_cmd("q0", cyc);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("hold%0d_valid", k), 32'(cmd_valid), 32'd1);
            check($sformatf("hold%0d_far", k),   cmd_far, f_far(jx[0]));
            check($sformatf("hold%0d_word", k),  32'(cmd_word), 32'(f_word(jx[0])));
            check($sformatf("hold%0d_data", k),  32'(cmd_data), 32'(ji[0]));
            check($sformatf("hold%0d_start", k), 32'(tr_start), 32'd1);
            tick();
        end
        cmd_ready = 1'b1;
        take_cmd("q0", jx[0], ji[0]);
        for (int k = 1; k < 5; k++) begin
            wait_cmd($sformatf("q%0d", k), cyc);
            take_cmd($sformatf("q%0d", k), jx[k], ji[k]);
        end
        check("q_stat_jobs", 32'(stat_jobs), STATS ? 32'd6 : 32'd0);
        check("q_busy_end", 32'(busy), 32'd0);

        // Timeout, then the next queued job completes normally
        m_never = 1'b1;
        push_one("to", 32'h0F0F_0F0E, 16'h1111);
        push_one("nx", 32'h3C3C_3C3D, 16'h2222);
        tick();
        check("to_run_start", 32'(tr_start), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            seen = seen | cmd_valid;
        end
        check("to_no_cmd", 32'(seen), 32'd0);
        check("to_err_before", 32'(err_timeout), 32'd0);
        check("to_start_last_run", 32'(tr_start), 32'd1);
        tick();
        check("to_err_after", 32'(err_timeout), 32'd1);
        check("to_start_drop", 32'(tr_start), 32'd0);
        check("to_cmd_valid", 32'(cmd_valid), 32'd0);
        check("to_stat_timeouts", 32'(stat_timeouts), STATS ? 32'd1 : 32'd0);
        m_never = 1'b0;
        wait_cmd("nx", cyc);
        take_cmd("nx", 32'h3C3C_3C3D, 16'h2222);
        check("nx_err_sticky", 32'(err_timeout), 32'd1);
        check("nx_stat_jobs", 32'(stat_jobs), STATS ? 32'd7 : 32'd0);

        // Reset during RUN with two jobs queued
        push_one("r1", 32'h1111_2220, 16'h3333);
        push_one("r2", 32'h4444_5554, 16'h6666);
        push_one("r3", 32'h7777_8888, 16'h9999);
        check("r_in_run", 32'(tr_start), 32'd1);
        check("r_full_not", 32'(req_ready), 32'd1);
        Reset = 1'b1;
        #1;
        check("r_tr_reset_now", 32'(tr_reset), 32'd1);
        tick();
        check("r_req_ready", 32'(req_ready), 32'd1);
        check("r_busy", 32'(busy), 32'd0);
        check("r_cmd_valid", 32'(cmd_valid), 32'd0);
        check("r_tr_reset", 32'(tr_reset), 32'd1);
        check("r_err_clr", 32'(err_timeout), 32'd0);
        check("r_stat_jobs", 32'(stat_jobs), 32'd0);
        check("r_stat_to", 32'(stat_timeouts), 32'd0);
        Reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            seen = seen | cmd_valid | busy;
        end
        check("r_no_cmd_after", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
